// File: rtl/ntt_job_scheduler_if.sv
// Requester, configuration and NTT-wrapper control bus of ntt_job_scheduler.
// slave = scheduler side; master = requesters plus the wrapper's finish flag.
interface ntt_job_scheduler_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned BANKW = 2,
  parameter int unsigned CNT_W = 16
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       req_intt;
  logic [NREQ*BANKW-1:0] req_bank;
  logic                  cfg_btf_gs;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  ntt_rst;
  logic                  ntt_start;
  logic                  ntt_intt;
  logic                  ntt_btf_gs;
  logic                  ntt_finish;
  logic [BANKW-1:0]      mem_bank;
  logic [CNT_W-1:0]      job_count;
  logic                  timeout;

  modport slave (
    input  req, req_intt, req_bank, cfg_btf_gs, ntt_finish,
    output grant, done, busy, ntt_rst, ntt_start, ntt_intt, ntt_btf_gs, mem_bank, job_count,
           timeout
  );

  modport master (
    output req, req_intt, req_bank, cfg_btf_gs, ntt_finish,
    input  grant, done, busy, ntt_rst, ntt_start, ntt_intt, ntt_btf_gs, mem_bank, job_count,
           timeout
  );
endinterface

// File: rtl/ntt_job_scheduler.sv
// Round-robin scheduler sharing one NTT memory wrapper among NREQ requesters.
// Define NTT_SCHED_TIMEOUT_EN to add a sticky RUN-state watchdog.
module ntt_job_scheduler #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned BANKW      = 2,
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned START_HOLD = 12,
  parameter int unsigned TOUT_W     = 20,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  ntt_job_scheduler_if.slave io_bus
);
  localparam int unsigned PtrW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned MaxHold = (START_HOLD > CLR_CYCLES) ? START_HOLD : CLR_CYCLES;
  localparam int unsigned HoldW   = $clog2(MaxHold + 1);

  typedef enum logic [2:0] {StIdle, StArb, StClr, StStart, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [PtrW-1:0]  r_ptr, w_win, w_idx;
  logic             w_any;
  logic [BANKW-1:0] w_bank, r_bank;
  logic [NREQ-1:0]  r_grant, w_done;
  logic             r_intt, r_btf;
  logic [HoldW-1:0] r_hold;
  logic [CNT_W-1:0] r_jobs;
  logic             w_ntt_rst, w_ntt_start, w_run_end, w_count_en;

  // First asserted request at or after the round-robin pointer.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_idx  = '0;
    w_bank = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PtrW'((32'(r_ptr) + k) % NREQ);
      if (!w_any && io_bus.req[w_idx]) begin
        w_any  = 1'b1;
        w_win  = w_idx;
        w_bank = io_bus.req_bank[w_idx*BANKW +: BANKW];
      end
    end
  end

`ifdef NTT_SCHED_TIMEOUT_EN
  logic [TOUT_W-1:0] r_wd;
  logic              r_timeout, r_tmo_job, w_wd_hit;

  // Trips on the cycle the counter would reach all-ones, i.e. after 2^TOUT_W-1 RUN cycles.
  assign w_wd_hit = (r_wd == {{(TOUT_W-1){1'b1}}, 1'b0});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
      r_tmo_job <= 1'b0;
    end else begin
      r_wd <= (r_state == StRun) ? r_wd + 1'b1 : '0;
      if (r_state == StRun && !io_bus.ntt_finish && w_wd_hit) begin
        r_timeout <= 1'b1;
        r_tmo_job <= 1'b1;
      end else if (r_state == StArb) begin
        r_tmo_job <= 1'b0;
      end
    end
  end

  assign w_run_end      = io_bus.ntt_finish || w_wd_hit;
  assign w_count_en     = !r_tmo_job;
  assign io_bus.timeout = r_timeout;
`else
  logic w_unused_tout;
  assign w_unused_tout  = ^TOUT_W;
  assign w_run_end      = io_bus.ntt_finish;
  assign w_count_en     = 1'b1;
  assign io_bus.timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d   = r_state;
    w_ntt_rst   = 1'b1;
    w_ntt_start = 1'b0;
    w_done      = '0;
    unique case (r_state)
      StIdle:  if (|io_bus.req) w_state_d = StArb;
      StArb:   w_state_d = w_any ? StClr : StIdle;
      StClr:   if (r_hold == HoldW'(CLR_CYCLES - 1)) w_state_d = StStart;
      StStart: begin
        w_ntt_rst   = 1'b0;
        w_ntt_start = 1'b1;
        if (r_hold == HoldW'(START_HOLD - 1)) w_state_d = StRun;
      end
      StRun: begin
        w_ntt_rst = 1'b0;
        if (w_run_end) w_state_d = StDone;
      end
      StDone: begin
        w_done    = r_grant;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_intt  <= 1'b0;
      r_btf   <= 1'b0;
      r_bank  <= '0;
      r_hold  <= '0;
      r_jobs  <= '0;
    end else begin
      // Phase timer restarts on every state change.
      r_hold <= (w_state_d != r_state) ? '0 : r_hold + 1'b1;
      if (r_state == StArb && w_any) begin
        r_grant <= NREQ'(1) << w_win;
        r_intt  <= io_bus.req_intt[w_win];
        r_btf   <= io_bus.cfg_btf_gs;
        r_bank  <= w_bank;
        r_ptr   <= (w_win == PtrW'(NREQ - 1)) ? '0 : w_win + 1'b1;
      end
      if (r_state == StDone) begin
        r_grant <= '0;
        if (w_count_en) r_jobs <= r_jobs + 1'b1;
      end
    end
  end

  assign io_bus.grant      = r_grant;
  assign io_bus.done       = w_done;
  assign io_bus.busy       = (r_state != StIdle);
  assign io_bus.ntt_rst    = w_ntt_rst;
  assign io_bus.ntt_start  = w_ntt_start;
  assign io_bus.ntt_intt   = r_intt;
  assign io_bus.ntt_btf_gs = r_btf;
  assign io_bus.mem_bank   = r_bank;
  assign io_bus.job_count  = r_jobs;
endmodule
